reg_file: RTL

Parametrised multi-port register file; the successor to the fixed 8-bit register in the processor datapath. It holds DEPTH words of WIDTH bits, with one synchronous write port and two independent asynchronous read ports. It sits between the decode stage, which supplies the read addresses, and the writeback stage, which supplies the write port. It feeds the operand inputs of the ALU.

---
 rtl/reg_file.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//
// Parametrised register file for the processor datapath. It holds DEPTH words
// of WIDTH bits. The writeback stage drives the single synchronous write port.
// The decode stage drives the two independent asynchronous read ports, which
// feed the ALU operands.
//
// Parameters:
//   WIDTH    - data word width in bits (>= 1)
//   DEPTH    - number of registers (>= 2)
//   ZERO_REG - 1: register 0 reads as 0 and ignores writes
//              0: register 0 is ordinary storage
//   AW       - address width, derived from DEPTH (not meant to be overridden)
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset
//   we       in   1      write enable
//   waddr    in   AW     write address
//   wdata    in   WIDTH  write data
//   raddr_a  in   AW     read port A address
//   rdata_a  out  WIDTH  read port A data (combinational)
//   raddr_b  in   AW     read port B address
//   rdata_b  out  WIDTH  read port B data (combinational)
//   werr     out  1      registered: the previous cycle's write was dropped
//                        (address out of range, or hardwired register 0)
//
// Handshake: there is none. A write is taken on every rising edge where
// we=1 and rst=1. Reads are always valid and follow the address combinationally.
//
// Build option:
//   REG_FILE_BYPASS_EN - when defined, a legal write is forwarded to any read
//   port whose address matches waddr within the same cycle. When the macro is
//   undefined, a same-cycle read returns the old contents.
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             werr
);

    // DEPTH is compared at AW+1 bits so that the check stays meaningful
    // when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             werr_q;
    logic             werr_d;
    logic             wr_legal;

    // An address holds real storage if it is in range and is not the
    // hardwired zero register.
    function automatic logic addr_is_storage(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero_reg;
        in_range    = ({1'b0, a} < DEPTH_W);
        is_zero_reg = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero_reg;
    endfunction

    always_comb begin
        wr_legal = we && addr_is_storage(waddr);
    end

    // Next-state storage and error flag.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_legal) begin
            mem_d[waddr] = wdata;
        end
        // The flag is set only by a dropped write. Any other edge clears it,
        // including edges where we=0.
        werr_d = we && !wr_legal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            werr_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            werr_q <= werr_d;
        end
    end

    assign werr = werr_q;

    // Read ports. Forwarding is gated by rst so that reads are 0 during
    // reset even while a write is still being driven.
    always_comb begin
        rdata_a = '0;
        if (addr_is_storage(raddr_a)) begin
            rdata_a = mem_q[raddr_a];
        end
`ifdef REG_FILE_BYPASS_EN
        if (rst && wr_legal && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
`endif
    end

    always_comb begin
        rdata_b = '0;
        if (addr_is_storage(raddr_b)) begin
            rdata_b = mem_q[raddr_b];
        end
`ifdef REG_FILE_BYPASS_EN
        if (rst && wr_legal && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`endif
    end

endmodule
